ec_point_octet_decoder: RTL

//  Parses a SEC1 uncompressed EC point octet string (0x04 || X || Y, big-endian) arriving
//  as a byte stream and emits the X/Y affine coordinates as wide words with a status code.

---
 rtl/ec_codec_pkg.sv | 31 +++
 rtl/ec_field_lt.sv | 13 +
 rtl/ec_point_octet_decoder.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/ec_codec_pkg.sv
// rtl/ec_codec_pkg.sv - shared status codes, SEC1 prefixes and field moduli for the EC point codec
package ec_codec_pkg;

    typedef enum logic [2:0] {
        OK         = 3'd0,
        BAD_PREFIX = 3'd1,
        SHORT      = 3'd2,
        LONG       = 3'd3,
        INFINITY   = 3'd4,
        RANGE      = 3'd5
    } ec_err_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_XCOL,
        ST_YCOL,
        ST_DRAIN,
        ST_CHECK,
        ST_DONE
    } dec_state_e;

    localparam logic [7:0] SEC1_PREFIX_INF    = 8'h00;
    localparam logic [7:0] SEC1_PREFIX_UNCOMP = 8'h04;

    localparam logic [255:0] P256_P =
        256'hFFFFFFFF00000001000000000000000000000000FFFFFFFFFFFFFFFFFFFFFFFF;

    localparam logic [383:0] P384_P =
        384'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFFFF0000000000000000FFFFFFFF;

endpackage

// File: rtl/ec_field_lt.sv
// rtl/ec_field_lt.sv - combinational unsigned a < b over a field-element width
module ec_field_lt #(
    parameter int unsigned W = 256
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic         lt_o
);

    // Plain magnitude compare; coordinates and modulus are both unsigned big integers.
    assign lt_o = (a_i < b_i);

endmodule

// File: rtl/ec_point_octet_decoder.sv
// rtl/ec_point_octet_decoder.sv - SEC1 uncompressed point byte-stream parser; EC_POINT_RANGE_CHECK_EN adds X/Y < FIELD_P check
module ec_point_octet_decoder
    import ec_codec_pkg::*;
#(
    parameter int unsigned              COORD_BYTES = 32,
    parameter logic [8*COORD_BYTES-1:0] FIELD_P     = P256_P
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [7:0]               s_data,
    input  logic                     s_last,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [8*COORD_BYTES-1:0] m_x,
    output logic [8*COORD_BYTES-1:0] m_y,
    output logic [2:0]               m_err_code
);

    localparam int unsigned W  = 8 * COORD_BYTES;
    localparam int unsigned CW = (COORD_BYTES > 1) ? $clog2(COORD_BYTES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(COORD_BYTES - 1);

    dec_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  x_q, x_d;
    logic [W-1:0]  y_q, y_d;
    ec_err_e       err_q, err_d;
    logic          accept;

`ifdef EC_POINT_RANGE_CHECK_EN
    logic x_lt, y_lt;

    ec_field_lt #(.W(W)) u_x_lt (.a_i(x_q), .b_i(FIELD_P), .lt_o(x_lt));
    ec_field_lt #(.W(W)) u_y_lt (.a_i(y_q), .b_i(FIELD_P), .lt_o(y_lt));
`else
    logic unused_field_p;
    assign unused_field_p = ^FIELD_P;
`endif

    // Only one frame in flight: stop accepting bytes while checking or presenting a result.
    assign s_ready = rst_n && (state_q == ST_IDLE || state_q == ST_XCOL ||
                               state_q == ST_YCOL || state_q == ST_DRAIN);
    assign accept  = s_valid && s_ready;

    assign m_valid    = (state_q == ST_DONE);
    assign m_x        = (m_valid && err_q == OK) ? x_q : '0;
    assign m_y        = (m_valid && err_q == OK) ? y_q : '0;
    assign m_err_code = err_q;

    // State, counter, coordinate shift registers and latched status.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            err_q   <= OK;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            y_q     <= y_d;
            err_q   <= err_d;
        end
    end

    // Frame parser: the first error seen moves to DRAIN/DONE, so nothing later can overwrite it.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        y_d     = y_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    cnt_d = '0;
                    err_d = OK;
                    if (s_data == SEC1_PREFIX_UNCOMP) begin
                        if (s_last) begin
                            state_d = ST_DONE;
                            err_d   = SHORT;
                        end else begin
                            state_d = ST_XCOL;
                        end
                    end else if (s_data == SEC1_PREFIX_INF) begin
                        state_d = s_last ? ST_DONE : ST_DRAIN;
                        err_d   = s_last ? INFINITY : LONG;
                    end else begin
                        state_d = s_last ? ST_DONE : ST_DRAIN;
                        err_d   = BAD_PREFIX;
                    end
                end
            end
            ST_XCOL: begin
                if (accept) begin
                    x_d = {x_q[W-9:0], s_data};
                    if (s_last) begin
                        state_d = ST_DONE;
                        err_d   = SHORT;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = ST_YCOL;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            ST_YCOL: begin
                if (accept) begin
                    y_d = {y_q[W-9:0], s_data};
                    if (cnt_q == CNT_LAST) begin
`ifdef EC_POINT_RANGE_CHECK_EN
                        state_d = s_last ? ST_CHECK : ST_DRAIN;
`else
                        state_d = s_last ? ST_DONE : ST_DRAIN;
`endif
                        err_d   = s_last ? OK : LONG;
                    end else if (s_last) begin
                        state_d = ST_DONE;
                        err_d   = SHORT;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            ST_DRAIN: begin
                if (accept && s_last) begin
                    state_d = ST_DONE;
                end
            end
            ST_CHECK: begin
                state_d = ST_DONE;
`ifdef EC_POINT_RANGE_CHECK_EN
                if (!(x_lt && y_lt)) begin
                    err_d = RANGE;
                end
`endif
            end
            ST_DONE: begin
                if (m_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule
